// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART TX drain (UART_TX_PARITY_EN adds the PARITY state)
package uart_pkg;

  // Drain FSM states; PARITY only exists when the parity bit is built in
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_FETCH  = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd4,
`endif
    TX_STOP   = 3'd5
  } tx_state_t;

  // Line levels on the serial pin
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Supported number of stop bits
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - divide-by-clks_per_bit counter with synchronous clear and bit-boundary tick
module uart_baud_cnt #(
  parameter int clks_per_bit = 16,
  parameter int cnt_w        = $clog2(clks_per_bit)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  output logic             bit_tick_o,
  output logic [cnt_w-1:0] cnt_o
);

  localparam logic [cnt_w-1:0] CNT_LAST = cnt_w'(clks_per_bit - 1);

  logic [cnt_w-1:0] cnt_q;

  // Free-running bit-period counter; clear restarts the period at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + cnt_w'(1);
    end
  end

  assign bit_tick_o = (cnt_q == CNT_LAST);
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - pops the TX FIFO and serialises bytes as 8N1 frames (UART_TX_PARITY_EN adds a parity bit)
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int data_wd      = 8,
  parameter int clks_per_bit = 16,
  parameter int stop_bits    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_en,
`ifdef UART_TX_PARITY_EN
  input  logic               parity_odd,
`endif
  input  logic               fifo_empty,
  input  logic [data_wd-1:0] fifo_rd_data,
  output logic               fifo_rd_en,
  output logic               tx,
  output logic               busy,
  output logic               frame_done
);

  localparam int CNT_W  = $clog2(clks_per_bit);
  localparam int BIT_W  = $clog2(data_wd + 1);
  localparam int STOP_N = (stop_bits < STOP_BITS_MIN) ? STOP_BITS_MIN :
                          (stop_bits > STOP_BITS_MAX) ? STOP_BITS_MAX : stop_bits;

  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(data_wd - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_N - 1);
  // Baud count one clk before the bit boundary, so frame_done lands on the final clk
  localparam logic [CNT_W-1:0] PRE_TICK  = CNT_W'(clks_per_bit - 2);

  tx_state_t          state_q;
  logic [data_wd-1:0] shift_q;
  logic [data_wd-1:0] shift_d;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic               tx_q;
  logic               frame_done_q;
`ifdef UART_TX_PARITY_EN
  logic               parity_q;
`endif

  logic               pop;
  logic               baud_clr;
  logic               bit_tick;
  logic [CNT_W-1:0]   baud_cnt;

  // Pop is decoded from the current empty flag so a stale flag can never cause an underflow
  assign pop        = rst_n && (state_q == TX_IDLE) && tx_en && !fifo_empty;
  assign fifo_rd_en = pop;

  // Baud counter sits at 0 until the start bit begins
  assign baud_clr   = (state_q == TX_IDLE) || (state_q == TX_FETCH);
  assign shift_d    = shift_q >> 1;

  uart_baud_cnt #(
    .clks_per_bit (clks_per_bit),
    .cnt_w        (CNT_W)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (baud_clr),
    .bit_tick_o (bit_tick),
    .cnt_o      (baud_cnt)
  );

  // Drain FSM: tx and frame_done are registered alongside the state so the pin never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= LINE_IDLE;
      frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= (state_q == TX_STOP) && (bit_cnt_q == LAST_STOP) &&
                      (baud_cnt == PRE_TICK);
      case (state_q)
        TX_IDLE: begin
          tx_q <= LINE_IDLE;
          if (pop) begin
            state_q <= TX_FETCH;
          end
        end
        TX_FETCH: begin
          shift_q   <= fifo_rd_data;
          bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
          parity_q  <= (^fifo_rd_data) ^ parity_odd;
`endif
          tx_q      <= LINE_START;
          state_q   <= TX_START;
        end
        TX_START: begin
          if (bit_tick) begin
            tx_q    <= shift_q[0];
            state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bit_tick) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q      <= parity_q;
              state_q   <= TX_PARITY;
`else
              tx_q      <= LINE_IDLE;
              state_q   <= TX_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              shift_q   <= shift_d;
              tx_q      <= shift_d[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_tick) begin
            tx_q    <= LINE_IDLE;
            state_q <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          tx_q <= LINE_IDLE;
          if (bit_tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              state_q   <= TX_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        default: begin
          tx_q    <= LINE_IDLE;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != TX_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - self-checking bench for uart_tx_fifo_drain (UART_TX_PARITY_EN selects the parity build)
module tb_uart_tx_fifo_drain;

  localparam int CPB  = 16;
  localparam int STOP = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_N = 1;
`else
  localparam int PAR_N = 0;
`endif
  localparam int LEN_BITS = 1 + 8 + PAR_N + STOP;
  localparam int LEN      = LEN_BITS * CPB;
  localparam logic [15:0] MASK = 16'((1 << LEN_BITS) - 1);

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // start, data LSB first, stop; bit 0 = first on the wire
    logic       par;    // even parity of data
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, tx_en, fifo_empty, fifo_rd_en, tx, busy, frame_done;
  logic [7:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic       parity_odd;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.data_wd(8), .clks_per_bit(CPB), .stop_bits(STOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en),
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  int          vectors = 0, misc = 0;
  int          cyc = 0, pops = 0, pop_bad = 0, stray = 0, frames = 0;
  int          last_pop_cyc = -100, end_cyc = 0, k = 0, wave_err = 0;
  bit          pend = 0, have_end = 0, chk_gap = 0, in_frame = 0;
  logic [7:0]  fq[$];
  logic [15:0] sb[$];
  logic [15:0] cur_w, act_w;
  logic        s_tx, s_busy, s_rd_en;
  vec_t        vecs[5];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] mk(vec_t v);
`ifdef UART_TX_PARITY_EN
    return {5'h1f, 1'b1, v.par, v.line[8:0]};
`else
    return {6'h3f, v.line};
`endif
  endfunction

  task automatic push_byte(vec_t v);
    fq.push_back(v.data);
    sb.push_back(mk(v));
    if (!pend) fifo_empty = 1'b0;
  endtask

  // One clock: sample at negedge, monitor the line, serve FIFO pops, update empty after the edge
  task automatic step();
    int bitpos;
    @(negedge clk);
    cyc++;
    s_tx = tx; s_busy = busy; s_rd_en = fifo_rd_en;
    if (!rst_n) begin
      in_frame = 0;
      if (frame_done) stray++;
    end else begin
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1; k = 0; act_w = '0; wave_err = 0;
        if (sb.size() == 0) begin
          check("scoreboard_entry", 32'd0, 32'd1);
          cur_w = '1;
        end else begin
          cur_w = sb.pop_front();
        end
        check("pop_to_start_latency", 32'(cyc - last_pop_cyc), 32'd2);
        if (chk_gap && have_end) check("interframe_gap", 32'(cyc - end_cyc - 1), 32'd2);
      end
      if (in_frame) begin
        bitpos = k / CPB;
        if (tx !== cur_w[bitpos[3:0]]) wave_err++;
        if ((k % CPB) == CPB / 2) act_w[bitpos[3:0]] = tx;
        if (k == LEN - 1) begin
          check("frame_done_last_clk", 32'(frame_done), 32'd1);
          check("frame_bits", 32'(act_w), 32'(cur_w & MASK));
          check("frame_bit_timing", 32'(wave_err), 32'd0);
          frames++; in_frame = 0; end_cyc = cyc; have_end = 1;
        end else if (frame_done) begin
          stray++;
        end
        k++;
      end else if (frame_done) begin
        stray++;
      end
    end
    if (fifo_rd_en) begin
      pops++;
      last_pop_cyc = cyc;
      if (fifo_empty) pop_bad++;
      if (fq.size() != 0) fifo_rd_data = fq.pop_front();
      pend = 1;
    end
    @(posedge clk);
    #1;
    if (pend) begin
      fifo_empty = (fq.size() == 0);
      pend = 0;
    end
  endtask

  task automatic wait_frames(int n, int budget);
    int start = frames;
    int cnt = 0;
    while (frames < start + n && cnt < budget) begin
      step();
      cnt++;
    end
    check("frames_within_budget", 32'(frames - start), 32'(n));
  endtask

  task automatic wait_k(int target);
    int cnt = 0;
    while (!(in_frame && k == target) && cnt < 600) begin
      step();
      cnt++;
    end
    check("frame_position_reached", 32'(in_frame && k == target), 32'd1);
  endtask

  initial begin
    int p0, txlow;
    vecs[0] = '{8'h80, 10'h300, 1'b1};
    vecs[1] = '{8'h01, 10'h202, 1'b1};
    vecs[2] = '{8'hC3, 10'h386, 1'b0};
    vecs[3] = '{8'h07, 10'h20E, 1'b1};
    vecs[4] = '{8'h5A, 10'h2B4, 1'b0};

    rst_n = 1'b0; tx_en = 1'b1; fifo_empty = 1'b1; fifo_rd_data = 8'h00;
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
`endif

    // Reset held with a non-empty FIFO and tx_en high
    push_byte('{8'h55, 10'h2AA, 1'b0});
    repeat (3) step();
    check("reset_tx", 32'(s_tx), 32'd1);
    check("reset_rd_en", 32'(s_rd_en), 32'd0);
    check("reset_busy", 32'(s_busy), 32'd0);
    check("reset_pops", 32'(pops), 32'd0);
    rst_n = 1'b1;
    step();
    check("first_pop_after_release", 32'(s_rd_en), 32'd1);
    wait_frames(1, 400);
    check("single_byte_pops", 32'(pops), 32'd1);

    // Table of single frames
    for (int i = 0; i < 5; i++) begin
      p0 = pops;
      push_byte(vecs[i]);
      wait_frames(1, 400);
      repeat (3) step();
      check("vec_pops", 32'(pops - p0), 32'd1);
      check("vec_idle_busy", 32'(s_busy), 32'd0);
    end

    // Three queued bytes back to back
    chk_gap = 1; have_end = 0; p0 = pops;
    push_byte('{8'hA5, 10'h34A, 1'b0});
    push_byte('{8'h00, 10'h200, 1'b0});
    push_byte('{8'hFF, 10'h3FE, 1'b0});
    wait_frames(3, 1000);
    chk_gap = 0;
    repeat (2) step();
    check("b2b_pops", 32'(pops - p0), 32'd3);
    check("b2b_busy_low", 32'(s_busy), 32'd0);
    check("b2b_fifo_empty", 32'(fifo_empty), 32'd1);

    // Empty FIFO with tx enabled
    p0 = pops; txlow = 0;
    repeat (100) begin
      step();
      if (s_tx !== 1'b1) txlow++;
    end
    check("empty_no_pops", 32'(pops - p0), 32'd0);
    check("empty_tx_high", 32'(txlow), 32'd0);

    // tx_en dropped in the third data bit
    p0 = pops;
    push_byte('{8'h3C, 10'h278, 1'b0});
    push_byte('{8'h81, 10'h302, 1'b0});
    wait_k(3 * CPB + 4);
    tx_en = 1'b0;
    wait_frames(1, 400);
    repeat (100) step();
    check("txen_off_pops", 32'(pops - p0), 32'd1);
    check("txen_off_busy", 32'(s_busy), 32'd0);

    // Reset pulsed in the fifth data bit of 0x81
    push_byte('{8'h07, 10'h20E, 1'b1});
    tx_en = 1'b1;
    wait_k(5 * CPB + 4);
    check("tx_low_before_reset", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #2;
    check("tx_async_high", 32'(tx), 32'd1);
    check("busy_async_low", 32'(busy), 32'd0);
    check("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    p0 = pops;
    wait_frames(1, 400);
    repeat (3) step();
    check("post_reset_pops", 32'(pops - p0), 32'd1);

    check("no_pop_while_empty", 32'(pop_bad), 32'd0);
    check("no_stray_frame_done", 32'(stray), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Transmit-side consumer of the UART TX FIFO.
- Pops bytes through the FIFO's read port (rd_en / rd_data, one-cycle read latency, empty flag) and serialises them onto the tx line as 8N1-style frames.
- Sits between the TX FIFO and the pad. It is the reader for the FIFO that the host-side bus logic writes.

Parameters:
- data_wd, 8, data bits per frame; must match the FIFO data width.
- clks_per_bit, 16, clk cycles per UART bit (baud divisor), minimum 2.
- stop_bits, 1, number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_en  input  1  transmitter enable. Sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  data_wd  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  one-cycle pop request to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high from pop through the end of the stop bit(s).
- frame_done  output  1  one-cycle pulse on the last clk of the final stop bit.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE; tx=1, busy=0, fifo_rd_en=0, frame_done=0.
  - Shift register, bit counter and baud counter are 0.
  - Asserting reset mid-frame forces tx=1 immediately; the partial frame is abandoned and the popped byte is lost.
- FSM states: IDLE, FETCH, START, DATA, PARITY (feature only), STOP.
- IDLE:
  - If tx_en && !fifo_empty: fifo_rd_en=1 for exactly this cycle, go to FETCH.
  - Otherwise stay in IDLE, tx=1.
- FETCH (1 clk): capture fifo_rd_data into the shift register, clear the baud counter, go to START.
- START: tx=0 for clks_per_bit clks, then go to DATA.
- DATA:
  - data_wd bits, LSB first, each held for clks_per_bit clks.
  - Shift right at each bit boundary. The bit counter runs 0..data_wd-1.
  - After the last bit, go to PARITY if the feature is enabled, otherwise to STOP.
- STOP:
  - tx=1 for stop_bits*clks_per_bit clks.
  - frame_done pulses on the final clk, then go to IDLE.
- busy = (state != IDLE).
- tx is registered: no combinational path from state decode to the pin, no glitches.
- Latency: fifo_rd_en in cycle N → start-bit falling edge on tx at N+2.
- Back-to-back frames: the inter-frame gap is exactly 2 extra high clks (one IDLE cycle plus FETCH) beyond the stop bits.
- The FIFO is never popped while fifo_empty=1.
- At most one pop per frame.
- tx_en deasserted mid-frame: the current frame completes, then the block holds in IDLE.
- fifo_empty rising during a frame: no effect. The byte is already captured.
- Baud counter width is $clog2(clks_per_bit); it wraps to 0 at clks_per_bit-1.
- Bit counter width is $clog2(data_wd+1).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 = odd parity, 0 = even), sampled in FETCH.
  - PARITY state outputs ^data (even) or ~^data (odd) for clks_per_bit clks, between DATA and STOP.
  - Frame length becomes 1+data_wd+1+stop_bits bits.
- Undefined: no parity_odd port, no PARITY state; DATA goes directly to STOP.

Decomposition:
- uart_pkg holds:
  - the state enum typedef (tx_state_t);
  - localparams for the idle line level (1) and start level (0);
  - the supported stop_bits range.
- One natural sub-module, uart_baud_cnt: a divide-by-clks_per_bit counter with a clear input and a bit_tick output.
- The drain FSM instantiates uart_baud_cnt and owns everything else.

Test Plan:
- Reset with FIFO non-empty and tx_en=1: during rst_n=0, tx=1, fifo_rd_en=0, busy=0. The first pop occurs 1 clk after release.
- Single byte 0x55, clks_per_bit=16, stop_bits=1:
  - tx sequence is 0,1,0,1,0,1,0,1,0,1, each bit lasting 16 clks;
  - frame_done pulses at clk 160 after the start edge;
  - exactly one fifo_rd_en.
- Three bytes 0xA5, 0x00, 0xFF queued:
  - three frames with a 2-clk gap between each stop bit and the next start;
  - three pops;
  - busy deasserts once fifo_empty is seen in IDLE.
- fifo_empty=1 with tx_en=1 for 100 clks: zero pops; tx stays 1.
- tx_en dropped in the 3rd data bit of 0x3C: the frame completes correctly, then there are no further pops while tx_en=0.
- rst_n pulsed low in the 5th data bit: tx goes 1 asynchronously; after release the next FIFO byte transmits cleanly. With UART_TX_PARITY_EN and parity_odd=0, byte 0x07 sends parity bit 1.
